uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter; the transmit-side counterpart of the board's UART receive path.
- Sends 8N1 frames (optional even parity) from a small byte FIFO onto a single TX line.
- Runs in the pixel-clock domain (25 MHz) next to the game FSM.
- Used to report moves and turn state to the external controller.

Parameters:
- CLK_HZ, 25_000_000, input clock frequency in Hz.
- BAUD, 115200, line rate in bits per second.
- FIFO_DEPTH, 4, byte FIFO entries; must be a power of 2 and at least 2.
- CLKS_PER_BIT is a localparam = CLK_HZ/BAUD, integer-truncated (217 at defaults).
- CLKS_PER_BIT must be at least 2; this is enforced with an elaboration-time check.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  8  byte to transmit.
- data_valid  in  1  producer has a byte on data_in.
- data_ready  out  1  FIFO can accept a byte.
- serial_out  out  1  UART TX line; idle high.
- busy  out  1  frame in progress or FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte being shifted.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high, on ports clk/reset.
- Reset values: serial_out=1, data_ready=1, busy=0, fifo_count=0. The FIFO pointers, bit counter, baud counter and shift register are all cleared.
- Handshake: a byte is accepted on any edge where data_valid && data_ready. data_ready = (fifo_count != FIFO_DEPTH), driven combinationally from the registered count.
- Simultaneous push and pop: fifo_count stays the same.
- Push while full: impossible, because data_ready is low. data_valid held while full keeps the byte waiting; nothing is dropped or overwritten.
- FSM states: IDLE, START, DATA, PARITY (only when the macro is enabled), STOP.
- IDLE: serial_out=1. If the FIFO is non-empty, pop the head into the shift register, load baud_cnt=0, go to START.
- Start-bit latency: serial_out goes low on the edge after the byte enters an empty FIFO, i.e. 2 edges after the accepting edge.
- START: serial_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA: serial_out = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then the register shifts right. After bit_idx==7 completes, go to PARITY or STOP.
- STOP: serial_out=1 for CLKS_PER_BIT cycles. At the end of STOP:
  - if the FIFO is non-empty, pop and go directly to START (no extra idle cycle between frames);
  - otherwise go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- baud_cnt counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit transition. bit_idx is 3 bits.
- serial_out is registered, so there are no glitches.
- busy = (state != IDLE) || (fifo_count != 0).
- Reset mid-frame: on the next edge, serial_out=1, the state goes to IDLE, and queued bytes are discarded. No partial-frame completion.
- reset has priority over a simultaneous push.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit, the XOR of the 8 data bits, latched at pop, for CLKS_PER_BIT cycles. Frame becomes 8E1.
- Undefined: the PARITY state and its logic are not compiled. Frame is 8N1.

Decomposition:
- Package uart_pkg contains:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparams DEFAULT_CLK_HZ and DEFAULT_BAUD;
  - UART_DATA_BITS=8.
- Sub-module byte_fifo holds the FIFO.
  - Parameters: DEPTH, WIDTH.
  - Ports: clk, reset, push, pop, din, dout, count, full, empty.
  - Output: show-ahead dout, with push and pop allowed in the same cycle.
- uart_tx holds the FSM, baud counter and shift register.

Test Plan:
- Single byte: CLK_HZ=16, BAUD=1 (16 clk/bit); push 0x35 on an idle line.
  - serial_out low 2 edges after the accepting edge.
  - Bits then read 0,1,0,1,0,1,1,0,0 (start, then LSB first) and stop=1, each 16 cycles.
  - busy drops after 160 cycles.
- Back-to-back: push 0xA5 then 0x0F on consecutive cycles. The second start bit begins exactly at the end of the first stop bit, with no gap. Decoded bytes are 0xA5, 0x0F.
- Full FIFO: hold data_valid with 6 bytes, FIFO_DEPTH=4.
  - First byte popped; 4 queued; data_ready=0, fifo_count=4.
  - data_ready returns to 1 one cycle after the next pop.
  - All 6 bytes are transmitted in order.
- Reset mid-frame: assert reset during DATA bit 3 of 0x00 with 2 bytes queued.
  - Next edge: serial_out=1, fifo_count=0, busy=0.
  - Line stays high with no further frames.
- Parity (UART_TX_PARITY_EN defined): send 0x07 and 0x03.
  - Parity bits are 1 and 0 respectively.
  - Frame length is 176 cycles at 16 clk/bit.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART transmit path
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DEFAULT_CLK_HZ = 25_000_000;
    localparam int DEFAULT_BAUD   = 115200;
    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - show-ahead FIFO with simultaneous push/pop
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("byte_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-fed UART transmitter, 8N1 or 8E1 when UART_TX_PARITY_EN is defined
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int BAUD       = DEFAULT_BAUD,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  data_in,
    input  logic                        data_valid,
    output logic                        data_ready,
    output logic                        serial_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx: CLK_HZ/BAUD must be at least 2");
    end

    tx_state_t                 state;
    logic [UART_DATA_BITS-1:0] shift;
    logic [2:0]                bit_idx;
    logic [CW-1:0]             baud_cnt;
    logic                      bit_done;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [7:0]                fifo_dout;
`ifdef UART_TX_PARITY_EN
    logic                      parity_bit;
`endif

    assign data_ready = !fifo_full;
    assign bit_done   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign busy       = (state != IDLE) || (fifo_count != '0);
    // Popping at the end of STOP lets the next start bit follow with no idle gap.
    assign fifo_pop   = !fifo_empty && ((state == IDLE) || (state == STOP && bit_done));

    byte_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (data_valid && data_ready),
        .pop   (fifo_pop),
        .din   (data_in),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            serial_out <= 1'b1;
            shift      <= '0;
            bit_idx    <= '0;
            baud_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            if (state != IDLE) begin
                baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    serial_out <= 1'b1;
                    if (fifo_pop) begin
                        shift    <= fifo_dout;
                        baud_cnt <= '0;
                        state    <= START;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^fifo_dout;
`endif
                    end
                end
                START: begin
                    serial_out <= 1'b0;
                    if (bit_done) begin
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    serial_out <= shift[0];
                    if (bit_done) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    serial_out <= parity_bit;
                    if (bit_done) begin
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    serial_out <= 1'b1;
                    if (bit_done) begin
                        if (fifo_pop) begin
                            shift <= fifo_dout;
                            state <= START;
`ifdef UART_TX_PARITY_EN
                            parity_bit <= ^fifo_dout;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    serial_out <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx at 16 clocks per bit
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       serial_out;
    logic       busy;
    logic [2:0] fifo_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    vec_t       vecs [9];
    logic [7:0] tx_bytes [6];

    uart_tx #(
        .CLK_HZ(16),
        .BAUD(1),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .serial_out (serial_out),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_start(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (serial_out === 1'b0) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    // Called just after the start-bit edge; samples every bit at its midpoint.
    task automatic capture(output logic [10:0] bits);
        bits = '0;
        step(CPB / 2);
        for (int k = 0; k < NB; k++) begin
            bits[k] = serial_out;
            if (k < NB - 1) step(CPB);
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            step(1);
            n++;
        end
        check("drain_idle", busy, 1'b0);
        step(CPB);
    endtask

    initial begin
        logic [10:0] cap;
        logic [10:0] exp_frame;
        logic [10:0] cap2;
        bit          ok;
        int          lows;
        int          busy_seen;

        vecs[0] = '{8'h35, 1'b0};
        vecs[1] = '{8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b0};
        vecs[3] = '{8'h01, 1'b1};
        vecs[4] = '{8'h80, 1'b1};
        vecs[5] = '{8'h07, 1'b1};
        vecs[6] = '{8'h03, 1'b0};
        vecs[7] = '{8'h5A, 1'b0};
        vecs[8] = '{8'h6B, 1'b1};
        tx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        @(negedge clk);
        step(3);
        check("rst_serial_out", serial_out, 1'b1);
        check("rst_data_ready", data_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_fifo_count", fifo_count, 3'd0);
        reset = 1'b0;
        step(2);
        check("idle_serial_out", serial_out, 1'b1);

        for (int i = 0; i < 9; i++) begin
            data_in    = vecs[i].data;
            data_valid = 1'b1;
            check("vec_ready", data_ready, 1'b1);
            step(1);
            data_valid = 1'b0;
            check("vec_count_after_push", fifo_count, 3'd1);
            step(1);
            check("vec_line_high_e1", serial_out, 1'b1);
            step(1);
            check("vec_start_latency", serial_out, 1'b0);
            capture(cap);
`ifdef UART_TX_PARITY_EN
            exp_frame = {1'b1, vecs[i].par, vecs[i].data, 1'b0};
            check("vec_parity_bit", cap[9], vecs[i].par);
`else
            exp_frame = {1'b0, 1'b1, vecs[i].data, 1'b0};
`endif
            check("vec_frame", cap, exp_frame);
            step(6);
            check("vec_busy_last", busy, 1'b1);
            step(1);
            check("vec_busy_drop", busy, 1'b0);
            check("vec_line_idle", serial_out, 1'b1);
            step(3);
        end

        data_in    = 8'hA5;
        data_valid = 1'b1;
        step(1);
        data_in = 8'h0F;
        step(1);
        data_valid = 1'b0;
        step(1);
        check("b2b_start1", serial_out, 1'b0);
        capture(cap);
        step(7);
        check("b2b_stop_tail", serial_out, 1'b1);
        step(1);
        check("b2b_no_gap", serial_out, 1'b0);
        capture(cap2);
        check("b2b_byte1", cap[8:1], 8'hA5);
        check("b2b_byte2", cap2[8:1], 8'h0F);
        check("b2b_stop1", cap[NB-1], 1'b1);
        wait_idle(400);

        fork
            begin : pusher
                int  idx;
                int  t0;
                bit  acc;
                bit  seen;
                idx  = 0;
                t0   = 0;
                seen = 1'b0;
                data_in    = tx_bytes[0];
                data_valid = 1'b1;
                for (int c = 0; c < 600 && idx < 6; c++) begin
                    if (idx == 5 && !seen && data_ready === 1'b1) begin
                        seen = 1'b1;
                        check("full_ready_return", cyc - t0, 16 * NB + 1);
                    end
                    acc = data_ready;
                    step(1);
                    if (acc) begin
                        if (idx == 0) t0 = cyc;
                        idx++;
                        if (idx < 6) data_in = tx_bytes[idx];
                        else data_valid = 1'b0;
                        if (idx == 5) begin
                            check("full_ready_low", data_ready, 1'b0);
                            check("full_count", fifo_count, 3'd4);
                        end
                    end
                end
                data_valid = 1'b0;
                check("full_all_accepted", idx, 6);
            end
            begin : receiver
                logic [10:0] rb;
                bit          rok;
                for (int f = 0; f < 6; f++) begin
                    wait_start(400, rok);
                    check("full_frame_seen", rok, 1'b1);
                    if (!rok) break;
                    capture(rb);
                    check("full_byte_order", rb[8:1], tx_bytes[f]);
                end
            end
        join
        wait_idle(400);

        data_in    = 8'h00;
        data_valid = 1'b1;
        step(1);
        data_in = 8'h11;
        step(1);
        data_in = 8'h22;
        step(1);
        data_valid = 1'b0;
        check("rmf_queued", fifo_count, 3'd2);
        step(68);
        check("rmf_mid_data", serial_out, 1'b0);
        reset      = 1'b1;
        data_in    = 8'h55;
        data_valid = 1'b1;
        step(1);
        check("rmf_serial_out", serial_out, 1'b1);
        check("rmf_fifo_count", fifo_count, 3'd0);
        check("rmf_busy", busy, 1'b0);
        reset      = 1'b0;
        data_valid = 1'b0;
        lows      = 0;
        busy_seen = 0;
        for (int c = 0; c < 400; c++) begin
            step(1);
            if (serial_out !== 1'b1) lows++;
            if (busy !== 1'b0) busy_seen++;
        end
        check("rmf_line_quiet", lows, 0);
        check("rmf_stays_idle", busy_seen, 0);
        ok = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
